// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_rx_pkg
//  Description : Shared types and helpers for the oversampling UART receiver.
//                rx_state_t - receiver FSM states
//                calc_div   - clock cycles per oversample tick (rounded)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Rounded-to-nearest divider from system clock to oversample tick rate.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Clearable clock divider. Emits a one-cycle tick every DIV
//                cycles; i_clear restarts the period so the first tick lands
//                exactly DIV cycles after the clear cycle.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_clear  - restart the period (tick suppressed this cycle)
//                o_tick   - one-cycle tick
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_clear;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : 8N1-style UART receiver, OVERSAMPLE ticks per bit with a
//                2-of-3 majority vote around mid-bit. Flags false starts
//                (silently), framing errors and overruns. Output word is held
//                in a valid/ready register.
//  Ports       : clk         - system clock
//                reset       - synchronous active-high reset
//                ena         - receiver enable (low aborts the frame)
//                rx          - asynchronous serial input, idles high
//                data        - received word, stable while valid
//                valid       - word available
//                ready       - consumer accepts when valid && ready
//                framing_err - one-cycle pulse, stop bit sampled 0
//                overrun_err - one-cycle pulse, good frame while valid high
//                busy        - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int c_div   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int c_mid   = OVERSAMPLE / 2;
    localparam int c_k_w   = $clog2(OVERSAMPLE);
    localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Vote window sits at k = M-1, M, M+1; k = OVERSAMPLE-1 ends the bit.
    localparam logic [c_k_w-1:0]   c_k_vote0 = c_k_w'(c_mid - 1);
    localparam logic [c_k_w-1:0]   c_k_vote1 = c_k_w'(c_mid);
    localparam logic [c_k_w-1:0]   c_k_vote2 = c_k_w'(c_mid + 1);
    localparam logic [c_k_w-1:0]   c_k_end   = c_k_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);

    // Synchronizer and edge history
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_prev;

    // Receiver state
    rx_state_t             r_state;
    logic [c_k_w-1:0]      r_k;
    logic [c_bit_w-1:0]    r_bit;
    logic [1:0]            r_vote;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_armed;

    // Output register
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_framing_err;
    logic                  r_overrun_err;

    logic       w_edge;
    logic       w_start;
    logic       w_clear;
    logic       w_tick;
    logic [1:0] w_vote_sum;
    logic       w_maj;
    logic       w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_edge   = r_rx_prev & ~r_rx_s;
    assign w_start  = ena & r_armed & w_edge & (r_state == IDLE);
    // Divider restarts on the accepted edge so tick k=0 is DIV cycles later.
    assign w_clear  = ~ena | w_start;
    assign w_accept = r_valid & ready;

    // Two earlier votes (0..2) plus the current sample; bit 1 set means >= 2.
    assign w_vote_sum = r_vote + {1'b0, r_rx_s};
    assign w_maj      = w_vote_sum[1];

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_bit         <= '0;
            r_vote        <= '0;
            r_shift       <= '0;
            r_armed       <= 1'b1;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;

            if (w_accept) begin
                r_valid <= 1'b0;
            end

            // After a framing error the line must be seen idle before a new
            // falling edge is trusted, so a held break cannot retrigger.
            if (r_rx_s) begin
                r_armed <= 1'b1;
            end

            if (!ena) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_state <= START;
                            r_k     <= '0;
                            r_bit   <= '0;
                            r_vote  <= '0;
                        end
                    end
                    default: begin
                        if (w_tick) begin
                            r_k <= (r_k == c_k_end) ? '0 : r_k + 1'b1;

                            if (r_k == c_k_vote0) begin
                                r_vote <= {1'b0, r_rx_s};
                            end else if (r_k == c_k_vote1) begin
                                r_vote <= w_vote_sum;
                            end

                            case (r_state)
                                START: begin
                                    if ((r_k == c_k_vote2) && w_maj) begin
                                        r_state <= IDLE;       // false start
                                    end else if (r_k == c_k_end) begin
                                        r_state <= DATA;
                                    end
                                end
                                DATA: begin
                                    if (r_k == c_k_vote2) begin
                                        r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                                    end
                                    if (r_k == c_k_end) begin
                                        if (r_bit == c_bit_last) begin
                                            r_state <= STOP;
                                        end else begin
                                            r_bit <= r_bit + 1'b1;
                                        end
                                    end
                                end
                                STOP: begin
                                    // Decide at mid-stop to leave margin for a
                                    // back-to-back start edge.
                                    if (r_k == c_k_vote2) begin
                                        r_state <= IDLE;
                                        if (w_maj) begin
                                            if (!r_valid || w_accept) begin
                                                r_data  <= r_shift;
                                                r_valid <= 1'b1;
                                            end else begin
                                                r_overrun_err <= 1'b1;
                                            end
                                        end else begin
                                            r_framing_err <= 1'b1;
                                            r_armed       <= 1'b0;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign framing_err = r_framing_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
